// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcodes, command-master state type and default datapath width.
package alu_pkg;
  localparam int W_DEF = 4;
  typedef enum logic [2:0] {ADD = 3'b000, SUB = 3'b001, NOT = 3'b010, AND = 3'b011,
                            OR = 3'b100, XOR = 3'b101, LT = 3'b110, EQ = 3'b111} mode_e;
  typedef enum logic [1:0] {IDLE, DRIVE, WAIT, RESP} state_t;
endpackage

// File: rtl/alu.sv
// alu: two-stage registered ALU; inputs sampled one edge, result and flags stable the next.
module alu
  import alu_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         zero,
  output logic         ovf,
  output logic         d
);
  logic [2:0]   m_q;
  logic [W-1:0] a_q, b_q, y_c;
  logic         ovf_c, d_c;
  always_comb begin
    y_c   = '0;
    ovf_c = 1'b0;
    d_c   = 1'b0;
    case (mode_e'(m_q))
      ADD: begin
        y_c   = a_q + b_q;
        ovf_c = (a_q[W-1] == b_q[W-1]) && (y_c[W-1] != a_q[W-1]);
      end
      SUB: begin
        y_c   = a_q - b_q;
        ovf_c = (a_q[W-1] != b_q[W-1]) && (y_c[W-1] != a_q[W-1]);
      end
      NOT: y_c = ~a_q;
      AND: y_c = a_q & b_q;
      OR:  y_c = a_q | b_q;
      XOR: y_c = a_q ^ b_q;
      LT: begin
        d_c = $signed(a_q) < $signed(b_q);
        y_c = W'(d_c);
      end
      EQ: begin
        d_c = a_q == b_q;
        y_c = W'(d_c);
      end
      default: y_c = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_q  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      y    <= '0;
      zero <= 1'b0;
      ovf  <= 1'b0;
      d    <= 1'b0;
    end else begin
      m_q  <= mode;
      a_q  <= a;
      b_q  <= b;
      y    <= y_c;
      zero <= y_c == '0;
      ovf  <= ovf_c;
      d    <= d_c;
    end
  end
endmodule

// File: rtl/alu_cmd_master.sv
// alu_cmd_master: accepts one command at a time, drives a latency-LAT ALU,
// captures its result and flags and holds them until the response handshake.
module alu_cmd_master
  import alu_pkg::*;
#(
  parameter int LAT = 2,
  parameter int W   = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_mode,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic [3:0]   cmd_tag,
  output logic         alu_rst_n,
  output logic [2:0]   alu_mode,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_y,
  input  logic         alu_zero,
  input  logic         alu_ovf,
  input  logic         alu_d,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_y,
  output logic         rsp_zero,
  output logic         rsp_ovf,
  output logic         rsp_d,
  output logic [3:0]   rsp_tag,
  output logic         busy,
  output logic [7:0]   op_count
);
  localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    tag_q;
  assign alu_rst_n = ~rst;
  assign cmd_ready = state == IDLE && !rst;
  assign busy      = state != IDLE && !rst;
  // WAIT is held for LAT cycles so capture lands on edge k+LAT+1 after the accept at k
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      alu_mode  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      tag_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_zero  <= 1'b0;
      rsp_ovf   <= 1'b0;
      rsp_d     <= 1'b0;
      rsp_tag   <= '0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          alu_mode <= cmd_mode;
          alu_a    <= cmd_a;
          alu_b    <= cmd_b;
          tag_q    <= cmd_tag;
          state    <= DRIVE;
        end
        DRIVE: begin
          cnt   <= CW'(LAT - 1);
          state <= WAIT;
        end
        WAIT: if (cnt == '0) begin
          rsp_y     <= alu_y;
          rsp_zero  <= alu_zero;
          rsp_ovf   <= alu_ovf;
          rsp_d     <= alu_d;
          rsp_tag   <= tag_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end else cnt <= cnt - 1'b1;
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          op_count  <= op_count + 8'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_master.sv
// tb_alu_cmd_master: directed vectors, corner sequences and random ops against an integer ALU model.
module tb_alu_cmd_master;
  localparam int W = 4;
  localparam int LAT = 2;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, rsp_ready = 0;
  logic [2:0] cmd_mode = 0, alu_mode;
  logic [W-1:0] cmd_a = 0, cmd_b = 0, alu_a, alu_b, alu_y, rsp_y;
  logic [3:0] cmd_tag = 0, rsp_tag;
  logic alu_rst_n, alu_zero, alu_ovf, alu_d, rsp_valid, rsp_zero, rsp_ovf, rsp_d, busy;
  logic [7:0] op_count;
  int tests = 0, fails = 0, exp_cnt = 0;

  alu_cmd_master #(.LAT(LAT), .W(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag), .alu_rst_n(alu_rst_n), .alu_mode(alu_mode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .alu_d(alu_d), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_d(rsp_d), .rsp_tag(rsp_tag), .busy(busy),
    .op_count(op_count)
  );
  alu #(.W(W)) u_alu (
    .clk(clk), .rst_n(alu_rst_n), .mode(alu_mode), .a(alu_a), .b(alu_b),
    .y(alu_y), .zero(alu_zero), .ovf(alu_ovf), .d(alu_d)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] mode;
    logic [3:0] a, b, tag, y;
    logic zero, ovf, d;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // integer reference: {y, zero, ovf, d}
  function automatic logic [6:0] ref_alu(input int m, input int a, input int b);
    int sa, sb, r, y;
    bit o, d;
    sa = a > 7 ? a - 16 : a;
    sb = b > 7 ? b - 16 : b;
    o = 0; d = 0; y = 0;
    case (m)
      0: begin r = sa + sb; y = (a + b) & 15; o = r > 7 || r < -8; end
      1: begin r = sa - sb; y = (a - b) & 15; o = r > 7 || r < -8; end
      2: y = 15 - a;
      3: y = a & b;
      4: y = a | b;
      5: y = a ^ b;
      6: begin d = sa < sb; y = int'(d); end
      default: begin d = a == b; y = int'(d); end
    endcase
    return {4'(y), y == 0, o, d};
  endfunction

  task automatic run_op(input logic [2:0] m, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] tag, input int hold,
                        output logic [3:0] y, output logic z, output logic o, output logic dd);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("ready_before_accept", cmd_ready, 1);
    cmd_valid = 1; cmd_mode = m; cmd_a = a; cmd_b = b; cmd_tag = tag;
    @(posedge clk); #1;
    cmd_valid = 0; cmd_a = ~a; cmd_b = ~b;
    chk("busy_after_accept", busy, 1);
    chk("cmd_ready_busy", cmd_ready, 0);
    chk("alu_operands", {alu_mode, alu_a, alu_b}, {m, a, b});
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("rsp_latency", n, LAT + 1);
    chk("alu_operands_held", {alu_mode, alu_a, alu_b}, {m, a, b});
    chk("rsp_tag", rsp_tag, tag);
    y = rsp_y; z = rsp_zero; o = rsp_ovf; dd = rsp_d;
    repeat (hold) begin
      @(posedge clk); #1;
      chk("rsp_stable", {rsp_valid, rsp_y, rsp_zero, rsp_ovf, rsp_d, rsp_tag}, {1'b1, y, z, o, dd, tag});
      chk("cmd_ready_in_resp", cmd_ready, 0);
      chk("op_count_held", op_count, exp_cnt);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    exp_cnt = (exp_cnt + 1) % 256;
    chk("op_count_inc", op_count, exp_cnt);
    chk("rsp_valid_clear", rsp_valid, 0);
    chk("cmd_ready_after_hs", cmd_ready, 1);
  endtask

  initial begin
    logic [3:0] y;
    logic z, o, dd;
    logic [6:0] e;
    logic [2:0] m;
    logic [3:0] a, b, t;
    int seen;
    vt[0] = '{3'b000, 4'd3, 4'd4, 4'd1, 4'd7, 1'b0, 1'b0, 1'b0};
    vt[1] = '{3'b000, 4'd7, 4'd1, 4'd2, 4'd8, 1'b0, 1'b1, 1'b0};
    vt[2] = '{3'b001, 4'd5, 4'd5, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0};
    vt[3] = '{3'b111, 4'd6, 4'd6, 4'd4, 4'd1, 1'b0, 1'b0, 1'b1};
    vt[4] = '{3'b110, 4'b1000, 4'b0001, 4'd5, 4'd1, 1'b0, 1'b0, 1'b1};
    vt[5] = '{3'b110, 4'd3, 4'd2, 4'd6, 4'd0, 1'b1, 1'b0, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_op_count", op_count, 0);
    chk("reset_alu_rst_n", alu_rst_n, 0);
    chk("reset_regs", {rsp_y, rsp_tag, alu_a, alu_b, alu_mode}, 0);
    rst = 0;
    #1;
    chk("ready_after_reset", cmd_ready, 1);
    chk("alu_rst_n_release", alu_rst_n, 1);
    for (int i = 0; i < 6; i++) begin
      run_op(vt[i].mode, vt[i].a, vt[i].b, vt[i].tag, 0, y, z, o, dd);
      chk($sformatf("vec%0d_y", i), y, vt[i].y);
      chk($sformatf("vec%0d_zero", i), z, vt[i].zero);
      chk($sformatf("vec%0d_ovf", i), o, vt[i].ovf);
      if (vt[i].mode[2:1] == 2'b11) chk($sformatf("vec%0d_d", i), dd, vt[i].d);
    end
    run_op(3'b101, 4'd9, 4'd3, 4'd7, 5, y, z, o, dd);
    chk("hold5_y", y, 10);
    @(posedge clk); #1;
    cmd_valid = 1; cmd_mode = 3'b000; cmd_a = 4'd1; cmd_b = 4'd1; cmd_tag = 4'd9;
    @(posedge clk); #1;
    cmd_valid = 0;
    @(posedge clk); #1;
    chk("busy_in_wait", busy, 1);
    rst = 1;
    #1;
    chk("alu_rst_n_in_reset", alu_rst_n, 0);
    @(posedge clk); #1;
    chk("rst_wait_busy", busy, 0);
    chk("rst_wait_rsp_valid", rsp_valid, 0);
    chk("rst_wait_op_count", op_count, 0);
    chk("rst_wait_cmd_ready", cmd_ready, 0);
    rst = 0;
    exp_cnt = 0;
    #1;
    chk("rst_wait_ready_after", cmd_ready, 1);
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (rsp_valid) seen++; end
    chk("rst_wait_no_response", seen, 0);
    chk("rst_wait_count_stays", op_count, 0);
    for (int i = 0; i < 260; i++) begin
      m = 3'($urandom_range(0, 7));
      a = 4'($urandom);
      b = 4'($urandom);
      t = 4'($urandom);
      run_op(m, a, b, t, $urandom_range(0, 2), y, z, o, dd);
      e = ref_alu(int'(m), int'(a), int'(b));
      chk("rand_y", y, e[6:3]);
      chk("rand_zero", z, e[2]);
      chk("rand_ovf", o, e[1]);
      if (m[2:1] == 2'b11) chk("rand_d", dd, e[0]);
    end
    chk("op_count_wrapped", op_count, 260 % 256);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
